// File: rtl/dfd_trace_wr_sched.sv
// dfd_trace_wr_sched: round-robin scheduler sharing one trace AXI write master among circular-buffer sources; define DFD_TRACE_SCHED_STOP_ON_WRAP_EN for stop-on-full.
module dfd_trace_wr_sched #(
  parameter int NUM_SRC = 4,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int PTR_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic [NUM_SRC-1:0]                  cfg_en_i,
  input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0]   cfg_base_i,
  input  logic [NUM_SRC*PTR_WIDTH-1:0]        cfg_size_i,
  output logic [NUM_SRC*PTR_WIDTH-1:0]        wptr_o,
  output logic [NUM_SRC-1:0]                  wrap_o,
  output logic                                mst_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mst_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]           mst_data_o,
  input  logic                                mst_ready_i,
  output logic                                busy_o
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LS = $clog2(AXI_DATA_WIDTH / 8);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int PW = PTR_WIDTH;
  typedef enum logic [1:0] {IDLE, GRANT, ISSUE} state_t;
  state_t state, state_n;
  logic [SW-1:0] rr_last, sel, pick, lo, hi;
  logic has_hi, any, accept;
  logic [NUM_SRC-1:0] elig, en_q, stop;
  logic [PW-1:0] wptr [NUM_SRC];
  logic [PW-1:0] size_q;
`ifdef DFD_TRACE_SCHED_STOP_ON_WRAP_EN
  assign stop = wrap_o;
`else
  assign stop = '0;
`endif
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign elig[i] = src_valid_i[i] & cfg_en_i[i] & (cfg_size_i[i*PW +: PW] != '0) & ~stop[i];
    assign wptr_o[i*PW +: PW] = wptr[i];
  end
  assign busy_o = state != IDLE;
  // lo = lowest eligible index, hi = lowest eligible above rr_last; prefer hi
  always_comb begin
    lo = '0;
    hi = '0;
    has_hi = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (elig[k]) begin
        lo = SW'(k);
        if (k > int'(rr_last)) begin
          hi = SW'(k);
          has_hi = 1'b1;
        end
      end
    any = |elig;
    pick = has_hi ? hi : lo;
    accept = mst_valid_o & mst_ready_i;
    state_n = state == IDLE  ? (any ? GRANT : IDLE) :
              state == GRANT ? (any ? ISSUE : IDLE) :
                               (accept ? IDLE : ISSUE);
    src_ready_o = (state == GRANT && any) ? NUM_SRC'(1'b1) << pick : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rr_last <= SW'(NUM_SRC - 1);
      sel <= '0;
      size_q <= '0;
      mst_valid_o <= 1'b0;
      mst_addr_o <= '0;
      mst_data_o <= '0;
      en_q <= '0;
      wrap_o <= '0;
      for (int k = 0; k < NUM_SRC; k++) wptr[k] <= '0;
    end else begin
      state <= state_n;
      en_q <= cfg_en_i;
      if (state == GRANT && any) begin
        rr_last <= pick;
        sel <= pick;
        size_q <= cfg_size_i[int'(pick)*PW +: PW];
        mst_valid_o <= 1'b1;
        mst_addr_o <= cfg_base_i[int'(pick)*AW +: AW] + (AW'(wptr[pick]) << LS);
        mst_data_o <= src_data_i[int'(pick)*DW +: DW];
      end else if (accept) begin
        mst_valid_o <= 1'b0;
      end
      // re-arm beats a same-cycle pointer update
      for (int k = 0; k < NUM_SRC; k++)
        if (cfg_en_i[k] & ~en_q[k]) begin
          wptr[k] <= '0;
          wrap_o[k] <= 1'b0;
        end else if (accept && sel == SW'(k)) begin
          if (wptr[k] >= size_q - 1'b1) begin
            wptr[k] <= '0;
            wrap_o[k] <= 1'b1;
          end else begin
            wptr[k] <= wptr[k] + 1'b1;
          end
        end
    end
  end
endmodule

// File: tb/tb_dfd_trace_wr_sched.sv
// tb_dfd_trace_wr_sched: directed scenarios against dfd_trace_wr_sched with a paced master model.
module tb_dfd_trace_wr_sched;
  localparam int N = 4, AW = 64, DW = 512, PW = 16;
  logic clk = 1'b0, rst_i = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] src_valid_i = '0, src_ready_o, cfg_en_i = '0, wrap_o;
  logic [N*DW-1:0] src_data_i;
  logic [N*AW-1:0] cfg_base_i = '0;
  logic [N*PW-1:0] cfg_size_i = '0, wptr_o;
  logic mst_valid_o, mst_ready_i = 1'b1, busy_o;
  logic [AW-1:0] mst_addr_o;
  logic [DW-1:0] mst_data_o;
  int n_chk = 0, n_fail = 0;
  int seq[N];
  int n_acc = 0, n_gnt = 0, multi = 0, pulse_idx = 0, lat = 3, cnt = 0;
  logic [AW-1:0] acc_addr[64];
  logic [DW-1:0] acc_data[64];
  int gnt_log[64];
  bit auto_rdy = 1'b1, acc_flag = 1'b0, pulse_flag = 1'b0;

  dfd_trace_wr_sched dut (
    .clk_i(clk), .rst_i(rst_i), .src_valid_i(src_valid_i), .src_data_i(src_data_i),
    .src_ready_o(src_ready_o), .cfg_en_i(cfg_en_i), .cfg_base_i(cfg_base_i),
    .cfg_size_i(cfg_size_i), .wptr_o(wptr_o), .wrap_o(wrap_o), .mst_valid_o(mst_valid_o),
    .mst_addr_o(mst_addr_o), .mst_data_o(mst_data_o), .mst_ready_i(mst_ready_i), .busy_o(busy_o)
  );

  always_comb for (int i = 0; i < N; i++) src_data_i[i*DW +: DW] = DW'(i * 256 + seq[i]);

  always @(negedge clk) if (!rst_i) begin
    if (mst_valid_o && mst_ready_i) begin
      if (n_acc < 64) begin
        acc_addr[n_acc] = mst_addr_o;
        acc_data[n_acc] = mst_data_o;
      end
      n_acc++;
      acc_flag = 1'b1;
    end
    if (src_ready_o != '0) begin
      if ($countones(src_ready_o) != 1) multi++;
      for (int i = 0; i < N; i++) if (src_ready_o[i]) pulse_idx = i;
      if (n_gnt < 64) gnt_log[n_gnt] = pulse_idx;
      n_gnt++;
      pulse_flag = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pulse_flag) begin
      pulse_flag = 1'b0;
      seq[pulse_idx]++;
    end
    if (auto_rdy) begin
      if (acc_flag) begin
        acc_flag = 1'b0;
        mst_ready_i = 1'b0;
        cnt = lat;
      end else if (!mst_ready_i) begin
        if (cnt > 0) cnt--;
        if (cnt == 0) mst_ready_i = 1'b1;
      end
    end else acc_flag = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    src_valid_i = '0;
    cfg_en_i = '0;
    repeat (2) cycle();
    mst_ready_i = 1'b1;
    cnt = 0;
    lat = 3;
    acc_flag = 1'b0;
    pulse_flag = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    rst_i = 1'b0;
    n_acc = 0;
    n_gnt = 0;
    multi = 0;
  endtask

  task automatic wait_acc(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (n_acc >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    repeat (2) cycle();
    n_chk++; if (mst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", mst_valid_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    n_chk++; if (src_ready_o !== '0) begin n_fail++; $display("FAIL rst_ready got=%h exp=0", src_ready_o); end
    n_chk++; if (wptr_o !== '0) begin n_fail++; $display("FAIL rst_wptr got=%h exp=0", wptr_o); end
    n_chk++; if (wrap_o !== '0) begin n_fail++; $display("FAIL rst_wrap got=%h exp=0", wrap_o); end
    n_chk++; if (mst_addr_o !== '0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", mst_addr_o); end
    n_chk++; if (mst_data_o !== '0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", mst_data_o[31:0]); end
  endtask

  task automatic test_single();
    bit ok;
    logic [AW-1:0] ea[5];
    ea = '{64'h1000, 64'h1040, 64'h1080, 64'h10C0, 64'h1000};
    do_reset();
    cfg_base_i[0 +: AW] = 64'h1000;
    cfg_size_i[0 +: PW] = 16'd4;
    cfg_en_i = 4'b0001;
    src_valid_i = 4'b0001;
    wait_acc(3, ok);
    n_chk++; if (!ok || wrap_o[0] !== 1'b0) begin n_fail++; $display("FAIL single_wrap3 got=%b exp=0 ok=%0d", wrap_o[0], ok); end
    wait_acc(4, ok);
    n_chk++; if (!ok || wrap_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_wrap4 got=%b exp=1 ok=%0d", wrap_o[0], ok); end
    wait_acc(5, ok);
    src_valid_i = '0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout acc=%0d exp=5", n_acc); end
    repeat (3) cycle();
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (acc_addr[k] !== ea[k]) begin n_fail++; $display("FAIL single_addr%0d got=%h exp=%h", k, acc_addr[k], ea[k]); end
      n_chk++; if (acc_data[k] !== DW'(k)) begin n_fail++; $display("FAIL single_data%0d got=%h exp=%h", k, acc_data[k][31:0], k); end
    end
    n_chk++; if (wptr_o[0 +: PW] !== 16'd1) begin n_fail++; $display("FAIL single_wptr got=%0d exp=1", wptr_o[0 +: PW]); end
    n_chk++; if (n_acc !== 5) begin n_fail++; $display("FAIL single_count got=%0d exp=5", n_acc); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int eg[6];
    eg = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < N; i++) begin
      cfg_base_i[i*AW +: AW] = AW'(32'h10000 * (i + 1));
      cfg_size_i[i*PW +: PW] = 16'd8;
    end
    cfg_en_i = '1;
    src_valid_i = '1;
    wait_acc(6, ok);
    src_valid_i = '0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout acc=%0d exp=6", n_acc); end
    repeat (3) cycle();
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (gnt_log[k] !== eg[k]) begin n_fail++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, gnt_log[k], eg[k]); end
    end
    n_chk++; if (n_gnt !== 6) begin n_fail++; $display("FAIL rr_pulses got=%0d exp=6", n_gnt); end
    n_chk++; if (multi !== 0) begin n_fail++; $display("FAIL rr_multi got=%0d exp=0", multi); end
    n_chk++; if (acc_addr[4] !== 64'h10040) begin n_fail++; $display("FAIL rr_addr4 got=%h exp=10040", acc_addr[4]); end
    n_chk++; if (acc_data[5] !== DW'(257)) begin n_fail++; $display("FAIL rr_data5 got=%h exp=101", acc_data[5][31:0]); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    auto_rdy = 1'b0;
    mst_ready_i = 1'b0;
    cfg_base_i[0 +: AW] = 64'h2000;
    cfg_size_i[0 +: PW] = 16'd8;
    cfg_en_i = 4'b0001;
    src_valid_i = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle();
      ok = mst_valid_o;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_novalid got=%b exp=1", mst_valid_o); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_chk++;
      if ({mst_valid_o, mst_addr_o, mst_data_o} !== {1'b1, 64'h2000, DW'(0)}) begin
        n_fail++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/2000/0", k, mst_valid_o, mst_addr_o, mst_data_o[31:0]);
      end
    end
    n_chk++; if (n_gnt !== 1) begin n_fail++; $display("FAIL stall_pulses got=%0d exp=1", n_gnt); end
    cycle();
    mst_ready_i = 1'b1;
    src_valid_i = '0;
    cycle();
    mst_ready_i = 1'b0;
    repeat (3) cycle();
    n_chk++; if (n_acc !== 1) begin n_fail++; $display("FAIL stall_acc got=%0d exp=1", n_acc); end
    n_chk++; if (mst_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_valid_after got=%b exp=0", mst_valid_o); end
    auto_rdy = 1'b1;
  endtask

  task automatic test_size0_rearm();
    bit ok;
    int eg[8];
    eg = '{0, 2, 3, 0, 2, 3, 0, 2};
    do_reset();
    for (int i = 0; i < N; i++) cfg_base_i[i*AW +: AW] = AW'(32'h10000 * (i + 1));
    cfg_size_i = {16'd4, 16'd2, 16'd0, 16'd4};
    cfg_en_i = '1;
    src_valid_i = '1;
    wait_acc(8, ok);
    src_valid_i = '0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL sz0_timeout acc=%0d exp=8", n_acc); end
    repeat (3) cycle();
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (gnt_log[k] !== eg[k]) begin n_fail++; $display("FAIL sz0_grant%0d got=%0d exp=%0d", k, gnt_log[k], eg[k]); end
    end
    n_chk++; if (acc_addr[7] !== 64'h30000) begin n_fail++; $display("FAIL sz0_overwrite got=%h exp=30000", acc_addr[7]); end
    n_chk++; if (wptr_o[1*PW +: PW] !== 16'd0) begin n_fail++; $display("FAIL sz0_wptr1 got=%0d exp=0", wptr_o[1*PW +: PW]); end
    n_chk++; if (wptr_o[0 +: PW] !== 16'd3) begin n_fail++; $display("FAIL sz0_wptr0 got=%0d exp=3", wptr_o[0 +: PW]); end
    cfg_en_i = 4'b1011;
    repeat (3) cycle();
    n_chk++; if ({wrap_o[2], wptr_o[2*PW +: PW]} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL rearm_hold got=%b/%0d exp=1/1", wrap_o[2], wptr_o[2*PW +: PW]); end
    cfg_en_i = 4'b1111;
    cycle();
    n_chk++; if ({wrap_o[2], wptr_o[2*PW +: PW]} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL rearm_clear got=%b/%0d exp=0/0", wrap_o[2], wptr_o[2*PW +: PW]); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    do_reset();
    lat = 50;
    for (int i = 0; i < N; i++) begin
      cfg_base_i[i*AW +: AW] = AW'(32'h10000 * (i + 1));
      cfg_size_i[i*PW +: PW] = 16'd8;
    end
    cfg_en_i = '1;
    src_valid_i = '1;
    wait_acc(1, ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle();
      ok = (n_gnt >= 2) && mst_valid_o;
    end
    n_chk++; if (!ok || gnt_log[1] !== 1) begin n_fail++; $display("FAIL rmid_setup got=%0d exp=1 ok=%0d", gnt_log[1], ok); end
    rst_i = 1'b1;
    cycle();
    n_chk++;
    if ({mst_valid_o, busy_o, wptr_o, wrap_o} !== '0) begin
      n_fail++; $display("FAIL rmid_clear got=%b/%b/%h/%h exp=0/0/0/0", mst_valid_o, busy_o, wptr_o, wrap_o);
    end
    lat = 3;
    mst_ready_i = 1'b1;
    cnt = 0;
    acc_flag = 1'b0;
    pulse_flag = 1'b0;
    n_gnt = 0;
    n_acc = 0;
    rst_i = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle();
      ok = n_gnt >= 1;
    end
    src_valid_i = '0;
    n_chk++; if (!ok || gnt_log[0] !== 0) begin n_fail++; $display("FAIL rmid_first got=%0d exp=0 ok=%0d", gnt_log[0], ok); end
    repeat (10) cycle();
  endtask

`ifdef DFD_TRACE_SCHED_STOP_ON_WRAP_EN
  task automatic test_stop_on_wrap();
    bit ok;
    do_reset();
    cfg_base_i[0 +: AW] = 64'h3000;
    cfg_size_i[0 +: PW] = 16'd2;
    cfg_en_i = 4'b0001;
    src_valid_i = 4'b0001;
    wait_acc(2, ok);
    repeat (10) cycle();
    n_chk++; if (!ok || n_gnt !== 2 || n_acc !== 2) begin n_fail++; $display("FAIL stop_held got=%0d/%0d exp=2/2", n_gnt, n_acc); end
    n_chk++; if (wrap_o[0] !== 1'b1) begin n_fail++; $display("FAIL stop_wrap got=%b exp=1", wrap_o[0]); end
    cfg_en_i = '0;
    cycle();
    cfg_en_i = 4'b0001;
    wait_acc(3, ok);
    src_valid_i = '0;
    n_chk++; if (!ok || acc_addr[2] !== 64'h3000) begin n_fail++; $display("FAIL stop_rearm got=%h exp=3000 ok=%0d", acc_addr[2], ok); end
    n_chk++; if (acc_data[2] !== DW'(2)) begin n_fail++; $display("FAIL stop_data got=%h exp=2", acc_data[2][31:0]); end
    repeat (3) cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_size0_rearm();
    test_reset_mid_issue();
`ifdef DFD_TRACE_SCHED_STOP_ON_WRAP_EN
    test_stop_on_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dfd_trace_wr_sched.md
Name: dfd_trace_wr_sched

Overview:
- Round-robin scheduler that shares one trace AXI write master among NUM_SRC trace sources.
- Each source owns a circular buffer in memory, defined by a base address and a size in lines.
- Block captures one line of trace data per grant, computes its address from the source's write pointer, and issues it over the master's valid/ready register-bus interface.
- Sits between the trace encoders/funnels and the trace AXI master.

Parameters:
- NUM_SRC, 4, number of trace sources (2..8).
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 512, line data width; one line = AXI_DATA_WIDTH/8 bytes.
- PTR_WIDTH, 16, write-pointer/size width in lines.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- src_valid_i  in  NUM_SRC  per-source line available.
- src_data_i  in  NUM_SRC*AXI_DATA_WIDTH  per-source line data; slice i = source i.
- src_ready_o  out  NUM_SRC  one-cycle pulse: line of source i consumed.
- cfg_en_i  in  NUM_SRC  source enable.
- cfg_base_i  in  NUM_SRC*AXI_ADDR_WIDTH  buffer base, line-aligned.
- cfg_size_i  in  NUM_SRC*PTR_WIDTH  buffer size in lines.
- wptr_o  out  NUM_SRC*PTR_WIDTH  current write pointer per source.
- wrap_o  out  NUM_SRC  sticky: buffer wrapped at least once.
- mst_valid_o  out  1  request to AXI master.
- mst_addr_o  out  AXI_ADDR_WIDTH  write address.
- mst_data_o  out  AXI_DATA_WIDTH  write data.
- mst_ready_i  in  1  AXI master ready.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; wptr = 0; wrap = 0; state = IDLE; rr_last = NUM_SRC-1, so source 0 has first priority.
- Eligibility: src_valid_i[i] & cfg_en_i[i] & (cfg_size[i] != 0). Size 0 means the source is never granted.
- IDLE: if any source is eligible, go to GRANT.
- GRANT (1 cycle):
  - Round-robin pick, starting at rr_last+1 and wrapping modulo NUM_SRC.
  - Pulse src_ready_o[w] this cycle.
  - Register mst_data_o = src_data[w] and mst_addr_o = base[w] + (wptr[w] << log2(AXI_DATA_WIDTH/8)), truncated to AXI_ADDR_WIDTH.
  - Set rr_last = w, set mst_valid_o, go to ISSUE.
  - If no source is still eligible in this cycle (valid dropped), return to IDLE with no pulse.
- ISSUE:
  - Hold mst_valid_o, addr and data stable until mst_valid_o & mst_ready_i.
  - On that cycle: clear mst_valid_o, advance wptr[w], go to IDLE.
- Pointer update: if wptr+1 >= cfg_size, wptr = 0 and wrap_o[w] = 1; otherwise wptr+1.
- Pacing: the master drops ready the cycle after acceptance and raises it after the B response. The earliest next ISSUE is 2 cycles after acceptance, and it stalls until ready returns. At most one request is outstanding.
- Throughput: one line per (2 + master round-trip) cycles.
- Re-arm: a rising edge of cfg_en_i[i] (registered previous value) clears wptr[i] and wrap_o[i] the next cycle. A source disabled mid-ISSUE still completes its in-flight line and pointer update.
- cfg_base and cfg_size are sampled in GRANT only; changes have no effect on a line already captured.
- Simultaneous re-arm edge and pointer update on the same source: the clear wins.
- No per-source data buffering: a source must hold src_data_i while src_valid_i is high and no src_ready_o pulse has arrived.

Optional Feature:
- Macro DFD_TRACE_SCHED_STOP_ON_WRAP_EN.
- Defined: stop-on-full mode. When a source's pointer wraps to 0, wrap_o is set and the source becomes ineligible, with no further src_ready_o, until it is re-armed via a cfg_en_i rising edge. Trace is never overwritten.
- Undefined: circular overwrite. The source stays eligible after wrap.

Test Plan:
- Single source, base=0x1000, size=4, master ready after 3-cycle B latency, 5 lines → addresses 0x1000, 0x1040, 0x1080, 0x10C0, 0x1000; wrap_o[0]=1 after the 4th acceptance; wptr_o=1 at the end.
- All 4 sources continuously valid → grant order 0,1,2,3,0,1; exactly one src_ready_o pulse per GRANT; never two pulses in one cycle.
- Hold mst_ready_i low 10 cycles during ISSUE → mst_valid_o, addr and data stable all 10 cycles; no src_ready_o pulses; exactly one acceptance when ready rises.
- cfg_size_i[1]=0 with src_valid_i[1]=1 → source 1 never granted; other sources unaffected. Deassert then reassert cfg_en_i[2] → wptr[2]=0 and wrap_o[2]=0 the next cycle.
- Assert rst_i mid-ISSUE → next cycle mst_valid_o=0, busy_o=0, all wptr=0, all wrap=0; after release, source 0 is granted first.
- With DFD_TRACE_SCHED_STOP_ON_WRAP_EN, size=2, 3 lines offered → 2 accepted, wrap_o=1, 3rd held with no src_ready_o until re-arm, then issued to base+0.
